// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply / unsigned divide unit.
// One operation takes 32 iterations (shift-add MUL, restoring DIVU/REMU),
// then a single-cycle DONE strobe. The unit stalls the pipeline while busy.
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] RS_i,
  input  logic [31:0] RT_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  RDaddr_o
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic        accept;
  logic [63:0] mul_step;
  logic [31:0] rem_cur;
  logic [31:0] quo_cur;
  logic        div_bit;
  logic [32:0] rem_shift;
  logic [33:0] trial;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [63:0] div_step;
  logic [63:0] acc_step;
  logic [31:0] final_result;

  // An operation is taken only from IDLE and only for a defined opcode.
  assign accept = (state_q == S_IDLE) && start_i && (op_i != OP_RSVD);

  // One iteration of the datapath for the current counter value.
  always_comb begin
    // Shift-add multiply: add the multiplicand shifted by the bit position
    // whenever that multiplier bit is set.
    mul_step = acc_q;
    if (b_q[cnt_q]) begin
      mul_step = acc_q + ({32'd0, a_q} << cnt_q);
    end

    // Restoring division: accumulator holds {partial remainder, quotient}.
    // Dividend bits are consumed MSB first. A zero divisor always "fits",
    // which yields all-ones quotient and remainder equal to the dividend.
    rem_cur   = acc_q[63:32];
    quo_cur   = acc_q[31:0];
    div_bit   = a_q[5'd31 - cnt_q];
    rem_shift = {rem_cur, div_bit};
    trial     = {1'b0, rem_shift} - {2'b00, b_q};
    q_bit     = ~trial[33];
    rem_next  = q_bit ? trial[31:0] : rem_shift[31:0];
    div_step  = {rem_next, quo_cur[30:0], q_bit};

    acc_step = (op_q == OP_MUL) ? mul_step : div_step;

    case (op_q)
      OP_REMU: final_result = acc_step[63:32];
      default: final_result = acc_step[31:0];
    endcase
  end

  // Next-state, datapath update and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (accept) begin
          a_d     = RS_i;
          b_d     = RT_i;
          op_d    = op_i;
          rd_d    = RDaddr_i;
          cnt_d   = 5'd0;
          acc_d   = 64'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        stall_o = 1'b1;
        acc_d   = acc_step;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          result_d = final_result;
          rd_out_d = rd_q;
        end
      end
      S_DONE: begin
        // The instruction that started us is still in ID/EX, so start_i is
        // deliberately ignored here; the pipeline advances on this edge.
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything: the aborted operation never publishes.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= OP_MUL;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign result_o = result_q;
  assign RDaddr_o = rd_out_q;

  // Opcode constants only referenced for readability of the decode.
  logic unused_ops;
  assign unused_ops = ^{OP_DIVU};

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, back-to-back,
// flush, reset and randomized operations checked against an arithmetic model.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ex_muldiv dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .RS_i    (rs),
    .RT_i    (rt),
    .RDaddr_i(rd),
    .flush_i (flush),
    .stall_o (stall),
    .done_o  (done),
    .result_o(result),
    .RDaddr_o(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  // Behavioural reference: plain arithmetic on 32-bit unsigned operands.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      2'b01: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op in an IDLE cycle and follow it to its DONE strobe.
  // Operand inputs are scrambled while busy: they must not matter.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp,
                        output int done_cyc);
    int  stall_cnt;
    bit  got;
    start = 1'b1; op = o; rs = a; rt = b; rd = d;
    #1;
    stall_cnt = stall ? 1 : 0;
    got = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
        chk({name, " stall_in_done"}, {31'd0, stall}, 32'd0);
        chk({name, " result"}, result, exp);
        chk({name, " rd"}, {27'd0, rd_out}, {27'd0, d});
      end else begin
        if (stall) stall_cnt++;
        rs = $urandom;
        rt = $urandom;
      end
    end
    chk({name, " done_seen"}, {31'd0, got}, 32'd1);
    chk({name, " stall_cycles"}, stall_cnt, 32'd33);
    $display("op=%0d a=0x%08h b=0x%08h rd=%0d -> result=0x%08h expected=0x%08h",
             o, a, b, d, result, exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c1, c2, dc, pulses;
    logic [31:0] last;

    vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42};
    vecs[1] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'd1};
    vecs[2] = '{2'b01, 32'd100,        32'd7,          5'd2,  32'd14};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd2};
    vecs[4] = '{2'b01, 32'h1234_5678,  32'd0,          5'd4,  32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h1234_5678,  32'd0,          5'd31, 32'h1234_5678};
    vecs[6] = '{2'b00, 32'h8000_0001,  32'd3,          5'd9,  32'h8000_0003};

    rst = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0; rd = '0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd", {27'd0, rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, dc);
    end

    // Reserved opcode: never accepted, never stalls, never completes.
    start = 1'b1; op = 2'b11; rs = 32'd5; rt = 32'd5; rd = 5'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rsvd stall", {31'd0, stall}, 32'd0);
      chk("rsvd done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rsvd result_hold", result, 32'h8000_0003);

    // Back-to-back: second op presented in the cycle right after DONE.
    run_op("b2b mul", 2'b00, 32'd3, 32'd4, 5'd10, 32'd12, c1);
    run_op("b2b divu", 2'b01, 32'd9, 32'd2, 5'd11, 32'd4, c2);
    chk("b2b spacing", c2 - c1, 32'd34);
    last = 32'd4;

    // Flush at RUN iteration 10.
    start = 1'b1; op = 2'b00; rs = 32'd123; rt = 32'd456; rd = 5'd12;
    @(negedge clk);                  // accepted, RUN counter 0
    repeat (10) @(negedge clk);      // counter 10
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush stall_after", {31'd0, stall}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush no_done", pulses, 32'd0);
    chk("flush result_hold", result, last);
    chk("flush rd_hold", {27'd0, rd_out}, 32'd11);

    // Asynchronous reset pulse mid-RUN (iteration 20).
    start = 1'b1; op = 2'b00; rs = 32'd99; rt = 32'd77; rd = 5'd13;
    @(negedge clk);
    repeat (20) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst stall", {31'd0, stall}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst rd", {27'd0, rd_out}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_op("post_rst mul", 2'b00, 32'd2, 32'd3, 5'd14, 32'd6, dc);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 2));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = ra;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, 5'($urandom), ref_model(ro, ra, rb), dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
- REQ-001: clk_i  input  1  rising-edge clock.
- REQ-002: rst_i  input  1  reset, asynchronous, active-high.
- REQ-003: start_i  input  1  high while the EX-stage instruction is a mul/div op (driven from registered ID/EX control).
- REQ-004: op_i  input  2  00 MUL (low 32 bits of product), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved.
- REQ-005: RS_i  input  32  operand A: multiplicand or dividend.
- REQ-006: RT_i  input  32  operand B: multiplier or divisor.
- REQ-007: RDaddr_i  input  5  destination register of the operation.
- REQ-008: flush_i  input  1  abort the in-flight operation.
- REQ-009: stall_o  output  1  hold request to the ID/EX and upstream registers.
- REQ-010: done_o  output  1  one-cycle strobe; result_o and RDaddr_o are valid.
- REQ-011: result_o  output  32  operation result.
- REQ-012: RDaddr_o  output  5  destination latched at accept.

Function
- REQ-013: The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-014: IDLE with start_i=1 and op_i!=11 at a rising edge -> accept.
  - Latch RS_i, RT_i, op_i and RDaddr_i.
  - Clear the 5-bit counter and 64-bit accumulator.
  - Go to RUN.
- REQ-015: IDLE with op_i=11 -> no accept; state stays IDLE, stall_o=0, done_o never asserts.
- REQ-016: RUN SHALL perform exactly 32 iterations, one per edge, incrementing the counter.
  - The 32nd edge (counter=31) -> DONE.
- REQ-017: MUL SHALL use the shift-add algorithm.
  - Each iteration adds the shifted multiplicand when the current multiplier bit is 1.
  - result_o = product[31:0]; identical for signed and unsigned operands.
- REQ-018: DIVU/REMU SHALL use unsigned restoring division, one quotient bit per iteration, MSB first.
- REQ-019: Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, with no exception or extra cycles.
- REQ-020: DONE SHALL last exactly one cycle with done_o=1 and result_o/RDaddr_o valid, then go to IDLE unconditionally.
  - start_i is ignored in DONE: the same instruction is still in ID/EX.
- REQ-021: stall_o SHALL be combinational: (state==IDLE and start_i and op_i!=11) or state==RUN.
  - stall_o is 0 in DONE, so ID/EX advances at the DONE->IDLE edge.
- REQ-022: Latency: accept edge E0, RUN edges E1..E32, done_o high in the cycle after E32.
  - stall_o is high for 33 consecutive cycles per operation.
- REQ-023: A new operation whose start_i is presented in the cycle after DONE SHALL be accepted (back-to-back, no bubble beyond IDLE).
- REQ-024: flush_i=1 at any edge SHALL force IDLE and suppress done_o for the aborted operation.
  - flush_i overrides a simultaneous start_i.
  - stall_o is still computed from the current state and inputs in that cycle.
- REQ-025: result_o and RDaddr_o SHALL hold their last DONE values until the next DONE.
- REQ-026: Operands SHALL be sampled only at accept; changes on RS_i/RT_i during RUN have no effect.

Reset
- REQ-027: rst_i=1 SHALL immediately force the following, independent of clk_i:
  - state=IDLE, counter=0, accumulator=0;
  - stall_o=0 when start_i=0, done_o=0, result_o=0, RDaddr_o=0.
- REQ-028: Reset asserted mid-RUN SHALL discard the operation; after release the block accepts a new start_i normally.

Verification
- REQ-029: MUL, RS=7, RT=6, RD=5 -> stall_o high 33 cycles, then done_o one cycle with result_o=42, RDaddr_o=5.
- REQ-030: MUL, RS=0xFFFFFFFF, RT=0xFFFFFFFF -> result_o=0x00000001; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- REQ-031: DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678; latency unchanged.
- REQ-032: Back-to-back MUL 3*4, then DIVU 9/2 presented the cycle after DONE -> done_o pulses with 12 then 4.
  - The two pulses are 34 cycles apart.
  - stall_o is low only in the DONE cycles.
- REQ-033: flush_i at RUN iteration 10 -> IDLE next cycle, no done_o, result_o keeps its previous value.
- REQ-034: rst_i pulse (between edges) at RUN iteration 20 -> outputs zero immediately; a following MUL 2*3 completes with 6.
